// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
// Shared definitions for the bit-serial subtractor: FSM state encoding and the
// default operand width.
// -----------------------------------------------------------------------------
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : serial_sub_pkg

// File: rtl/serial_sub_full_sub.sv
// -----------------------------------------------------------------------------
// half_sub / full_sub
// Combinational subtractor cells. full_sub is built from two half subtractors
// and an OR on their borrows, mirroring the full-adder-from-half-adders cell.
//
// half_sub ports:
//   x, y  in   operand bits (computes x - y)
//   d     out  difference bit  (x ^ y)
//   bo    out  borrow-out bit  (~x & y)
// full_sub ports:
//   x, y  in   operand bits (computes x - y - bin)
//   bin   in   borrow-in
//   d     out  difference bit
//   bout  out  borrow-out
// -----------------------------------------------------------------------------
module half_sub (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);
    assign d  = x ^ y;
    assign bo = ~x & y;
endmodule : half_sub

module full_sub (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic d0;
    logic bo0;
    logic bo1;

    half_sub u_hs0 (
        .x  (x),
        .y  (y),
        .d  (d0),
        .bo (bo0)
    );

    // Second stage subtracts the incoming borrow from the partial difference;
    // its borrow equals ~(x^y) & bin.
    half_sub u_hs1 (
        .x  (d0),
        .y  (bin),
        .d  (d),
        .bo (bo1)
    );

    assign bout = bo0 | bo1;
endmodule : full_sub

// File: rtl/serial_sub.sv
// -----------------------------------------------------------------------------
// serial_sub
// Bit-serial subtractor computing a - b - bin over WIDTH cycles, LSB first,
// with a single registered borrow and a start/done handshake.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   load request, honoured only in IDLE or DONE
//   a      in   minuend, latched on accepted start
//   b      in   subtrahend, latched on accepted start
//   bin    in   borrow-in, latched on accepted start
//   busy   out  high while bits are being produced
//   done   out  one-cycle pulse once diff/bout are final
//   diff   out  (a - b - bin) mod 2^WIDTH; partial while busy
//   bout   out  unsigned borrow-out (a < b + bin)
// -----------------------------------------------------------------------------
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               br_q, br_d;
    logic               bout_q, bout_d;

    logic               fs_d;
    logic               fs_bout;

    full_sub u_full_sub (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .bin  (br_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end

            SHIFT: begin
                // After WIDTH shifts the first-produced (LSB) bit has reached
                // diff[0], so the result needs no reordering.
                diff_d = {fs_d, diff_q[WIDTH-1:1]};
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                br_d   = fs_bout;
                if (cnt_q == CNT_LAST) begin
                    bout_d  = fs_bout;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule : serial_sub
